fifo_sram_prefetch: RTL
=======================

Name: fifo_sram_prefetch

Overview:
- Downstream read-side adapter for the BRAM-backed synchronous FIFO.
- Converts the FIFO's pop/fixed-read-latency interface (data valid RD_LATENCY cycles after pop) into a valid/ready stream for the consumer.
- Holds data stable under backpressure and sustains one word per cycle.
- Issues pops on credit, keeps an in-flight tracker, and lands returning words in a small register skid buffer.

Parameters:
- DATA_WIDTH, 32, payload width; equals the upstream FIFO width.
- RD_LATENCY, 1, cycles from pop to valid fifo_data_i. 1 = no output register, 2 = output register enabled. Legal range 1..4.
- SKID_DEPTH, RD_LATENCY+1, skid buffer entries. Elaboration assertion requires SKID_DEPTH >= RD_LATENCY+1.
- CNT_W, $clog2(SKID_DEPTH+1), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  drop buffered and in-flight data; same signal that flushes the upstream FIFO
- fifo_empty_i  in  1  upstream FIFO empty
- fifo_data_i  in  DATA_WIDTH  upstream read data
- fifo_pop_o  out  1  upstream read enable
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts
- data_o  out  DATA_WIDTH  head of skid buffer
- usage_o  out  CNT_W  skid buffer occupancy, excluding in-flight words

Behaviour:
- Reset values (rst_i high):
  - valid_o=0, data_o=0, usage_o=0.
  - In-flight shift register cleared.
  - fifo_pop_o forced 0 combinationally while rst_i is high.
- In-flight tracker:
  - RD_LATENCY-deep shift register of valid bits; bit 0 is loaded with fifo_pop_o each cycle.
  - When the last bit is 1, fifo_data_i is written into the skid buffer at that clock edge.
  - inflight = popcount of the tracker.
- Credit rule:
  - fifo_pop_o = !fifo_empty_i & !flush_i & !flush_q & !rst_i & (usage + inflight - (valid_o & ready_i) < SKID_DEPTH).
  - flush_q is flush_i registered; it covers the upstream FIFO's one-cycle-delayed flush.
  - Buffer overflow is structurally impossible; the bench asserts it.
- Latency:
  - A pop in cycle t gives fifo_data_i valid in cycle t+RD_LATENCY. The word is written at the end of that cycle, so valid_o=1 in cycle t+RD_LATENCY+1.
  - There is no combinational bypass from fifo_data_i to data_o.
- Throughput: with ready_i held 1 and the FIFO non-empty, one word per cycle after the initial fill.
- Handshake:
  - A transfer occurs when valid_o & ready_i.
  - Once valid_o is asserted, valid_o and data_o stay stable until the transfer.
  - ready_i is ignored when valid_o=0.
- Simultaneous write and read of the skid buffer in the same cycle: usage unchanged, order preserved.
  - When the buffer is empty, a word written this cycle is not readable until the next cycle.
- Flush (synchronous, one cycle):
  - Skid buffer emptied and tracker cleared.
  - Any data returning in the flush cycle or in later cycles from earlier pops is discarded.
  - valid_o=0 from the next cycle.
  - fifo_pop_o=0 in the flush cycle and the following cycle.
  - Flush has priority over simultaneous write, read and pop.
- Pointers: wrap modulo SKID_DEPTH. SKID_DEPTH need not be a power of two; wrap by compare-and-clear.
- Reset mid-stream: everything cleared asynchronously. Words lost in flight are not recovered; the upstream FIFO is reset separately.

Decomposition:
- Package fifo_sram_pkg holds:
  - FIFO_SRAM_RD_LAT_NOREG=1 and FIFO_SRAM_RD_LAT_REG=2.
  - The default DATA_SPLIT of 32.
- Sub-module fifo_sram_skid_buf: register FIFO with SKID_DEPTH entries, push/pop, usage, flush, and asynchronous active-high reset.
- The top level holds the tracker, the credit logic and flush_q.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, ready_i=1, RD_LATENCY=1 -> pop in cycles 0,1,2; valid_o cycles 2,3,4 with data 0x11,0x22,0x33; fifo_pop_o=0 from cycle 3.
- Continuous stream of 100 words, ready_i=1, RD_LATENCY=2, SKID_DEPTH=3 -> 100 transfers in 103 cycles, no bubbles after the first valid_o.
- ready_i=0 with FIFO holding 10 words -> exactly SKID_DEPTH pops issued; usage_o=SKID_DEPTH; data_o stable; release ready_i -> in-order delivery, no loss or duplication.
- flush_i pulsed while 2 words are in flight and 1 is buffered -> valid_o=0 next cycle, returning words dropped, fifo_pop_o=0 for 2 cycles, next pushed word 0xAB is the first delivered.
- rst_i asserted asynchronously mid-transfer -> valid_o, usage_o and fifo_pop_o go to 0 immediately; after release, normal delivery resumes from fresh FIFO contents.
- Random ready_i (50%) and random push against a scoreboard -> data order matches and usage_o never exceeds SKID_DEPTH.

Source files
------------

// File: rtl/fifo_sram_pkg.sv
// Shared constants for the BRAM FIFO read-side adapter.
//   FIFO_SRAM_RD_LAT_NOREG / _REG : pop-to-data latency without / with the
//                                   BRAM output register
//   DATA_SPLIT                    : default payload width
//   fifo_sram_ptr_w()             : pointer width for a register FIFO depth
package fifo_sram_pkg;

  localparam int unsigned FIFO_SRAM_RD_LAT_NOREG = 1;
  localparam int unsigned FIFO_SRAM_RD_LAT_REG   = 2;
  localparam int unsigned FIFO_SRAM_RD_LAT_MAX   = 4;
  localparam int unsigned DATA_SPLIT             = 32;

  function automatic int unsigned fifo_sram_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sram_skid_buf.sv
// Small register FIFO that lands words returning from the BRAM FIFO.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : empties the buffer; wins over push and pop
//   push_i       : write wdata_i at the tail
//   pop_i        : drop the head (ignored while empty)
//   valid_o      : buffer non-empty
//   rdata_o      : head entry (0 while empty)
//   usage_o      : number of stored entries
module fifo_sram_skid_buf
  import fifo_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_SPLIT,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0]      usage_o
);

  localparam int unsigned PTR_W = fifo_sram_ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_pop;

  // DEPTH need not be a power of two: wrap by compare-and-clear
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop_i & (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign usage_o = cnt_q;

endmodule

// File: rtl/fifo_sram_prefetch.sv
// Read-side adapter: turns the BRAM FIFO's pop / fixed-latency data into a
// valid/ready stream. Pops are issued only when the skid buffer has room for
// every word already in flight, so returning data always has a slot.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : drop buffered and in-flight words (also flushes upstream)
//   fifo_empty_i  : upstream FIFO empty
//   fifo_data_i   : upstream read data, valid RD_LATENCY cycles after a pop
//   fifo_pop_o    : upstream read enable
//   valid_o/ready_i/data_o : consumer stream
//   usage_o       : skid buffer occupancy (in-flight words excluded)
module fifo_sram_prefetch
  import fifo_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_SPLIT,
  parameter int unsigned RD_LATENCY = FIFO_SRAM_RD_LAT_NOREG,
  parameter int unsigned SKID_DEPTH = RD_LATENCY + 1,
  parameter int unsigned CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      usage_o
);

  if (RD_LATENCY < 1 || RD_LATENCY > FIFO_SRAM_RD_LAT_MAX) begin : g_lat_chk
    $error("fifo_sram_prefetch: RD_LATENCY must be 1..4");
  end
  if (SKID_DEPTH < RD_LATENCY + 1) begin : g_skid_chk
    $error("fifo_sram_prefetch: SKID_DEPTH must be >= RD_LATENCY+1");
  end

  // One extra bit so usage + inflight cannot wrap
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [RD_LATENCY-1:0] trk_q, trk_d;
  logic                  flush_q, flush_d;
  logic [SUM_W-1:0]      inflight;
  logic [SUM_W-1:0]      occ;
  logic                  pop;
  logic                  land;
  logic                  xfer;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [CNT_W-1:0]      buf_usage;

  assign xfer = buf_valid & ready_i;
  // Tracker's oldest bit marks fifo_data_i as carrying a popped word this cycle
  assign land = trk_q[RD_LATENCY-1] & ~flush_i;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + SUM_W'(trk_q[i]);
    end
  end

  // Credit: a word leaving this cycle frees its slot for a pop this cycle.
  // flush_q covers the cycle where the upstream FIFO is still flushing.
  always_comb begin
    occ = SUM_W'(buf_usage) + inflight;
    pop = ~fifo_empty_i & ~flush_i & ~flush_q & ~rst_i &
          (occ < SUM_W'(SKID_DEPTH) + SUM_W'(xfer));
  end

  always_comb begin
    trk_d   = '0;
    flush_d = flush_i;
    if (!flush_i) begin
      trk_d[0] = pop;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        trk_d[i] = trk_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      trk_q   <= trk_d;
      flush_q <= flush_d;
    end
  end

  fifo_sram_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH),
    .CNT_W      (CNT_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (land),
    .wdata_i (fifo_data_i),
    .pop_i   (xfer),
    .valid_o (buf_valid),
    .rdata_o (buf_data),
    .usage_o (buf_usage)
  );

  assign fifo_pop_o = pop;
  assign valid_o    = buf_valid;
  assign data_o     = buf_data;
  assign usage_o    = buf_usage;

endmodule
